// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: ride tracker states and river lane geometry.
package frogger_pkg;

    typedef enum logic [1:0] {
        LAND    = 2'd0,
        RIDE    = 2'd1,
        DROWN   = 2'd2,
        RESPAWN = 2'd3
    } ride_state_t;

    localparam int RIVER_Y    = 182;
    localparam int SPRITE_W   = 32;
    localparam int LEFT_BOUND = 207;

endpackage

// File: rtl/fish_ride_tracker_if.sv
// Signal bundle between the fish/frog controllers and the ride tracker.
interface fish_ride_tracker_if;

    logic [9:0] fish_x;
    logic [9:0] fish_y;
    logic       fish_moved;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       frog_landed;
    logic       respawn_ack;
    logic       riding;
    logic       frog_push;
    logic       drowned;
    logic       respawn_req;

    modport master (
        output fish_x, fish_y, fish_moved, frog_x, frog_y, frog_landed, respawn_ack,
        input  riding, frog_push, drowned, respawn_req
    );

    modport slave (
        input  fish_x, fish_y, fish_moved, frog_x, frog_y, frog_landed, respawn_ack,
        output riding, frog_push, drowned, respawn_req
    );

endinterface

// File: rtl/overlap_check.sv
// Combinational test: does the frog's horizontal centre fall on the fish sprite?
module overlap_check #(
    parameter int SPRITE_W = frogger_pkg::SPRITE_W
) (
    input  logic [9:0] frog_x,
    input  logic [9:0] fish_x,
    output logic       overlap
);

    // One extra bit so sprites near the right edge never wrap around.
    logic [10:0] frog_mid;
    logic [10:0] fish_lo;
    logic [10:0] fish_hi;

    assign frog_mid = {1'b0, frog_x} + 11'(SPRITE_W / 2);
    assign fish_lo  = {1'b0, fish_x};
    assign fish_hi  = {1'b0, fish_x} + 11'(SPRITE_W - 1);
    assign overlap  = (frog_mid >= fish_lo) && (frog_mid <= fish_hi);

endmodule

// File: rtl/fish_ride_tracker.sv
// Tracks whether the frog rides a fish, pushes it along with the fish, and
// sequences drowning and respawn.
module fish_ride_tracker #(
    parameter int RIVER_Y    = frogger_pkg::RIVER_Y,
    parameter int SPRITE_W   = frogger_pkg::SPRITE_W,
    parameter int LEFT_BOUND = frogger_pkg::LEFT_BOUND,
    parameter int DROWN_HOLD = 60
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    fish_ride_tracker_if.slave    bus
);

    localparam int CNT_W = (DROWN_HOLD > 1) ? $clog2(DROWN_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DROWN_HOLD - 1);

    frogger_pkg::ride_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       prev_fish_x_reg;
    logic             riding_reg;
    logic             drowned_reg;
    logic             respawn_req_reg;
    logic             push_ok;

    logic overlap;
    logic on_river;
    logic at_bound;
    logic fish_wrapped;
    logic fish_stepped;
    logic unused_fish_y;

    overlap_check #(
        .SPRITE_W (SPRITE_W)
    ) u_overlap (
        .frog_x  (bus.frog_x),
        .fish_x  (bus.fish_x),
        .overlap (overlap)
    );

    assign on_river      = (bus.frog_y == 10'(RIVER_Y));
    assign at_bound      = (bus.frog_x <= 10'(LEFT_BOUND));
    assign fish_wrapped  = (bus.fish_x > prev_fish_x_reg);
    assign fish_stepped  = (bus.fish_x == (prev_fish_x_reg - 10'd1));
    assign unused_fish_y = ^bus.fish_y;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        push_ok    = 1'b0;
        case (state_reg)
            frogger_pkg::LAND: begin
                if (bus.frog_landed && on_river) begin
                    state_next = overlap ? frogger_pkg::RIDE : frogger_pkg::DROWN;
                end
            end
            frogger_pkg::RIDE: begin
                // A completed hop outranks a fish step in the same cycle.
                if (bus.frog_landed) begin
                    if (!on_river) begin
                        state_next = frogger_pkg::LAND;
                    end else if (!overlap) begin
                        state_next = frogger_pkg::DROWN;
                    end
                end else if (bus.fish_moved) begin
                    if (fish_wrapped || at_bound) begin
                        state_next = frogger_pkg::DROWN;
                    end else begin
                        push_ok = fish_stepped;
                    end
                end
            end
            frogger_pkg::DROWN: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == HOLD_LAST) begin
                    state_next = frogger_pkg::RESPAWN;
                end
            end
            frogger_pkg::RESPAWN: begin
                if (bus.respawn_ack) begin
                    state_next = frogger_pkg::LAND;
                end
            end
            default: state_next = frogger_pkg::LAND;
        endcase
        if ((state_next == frogger_pkg::DROWN) && (state_reg != frogger_pkg::DROWN)) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg       <= frogger_pkg::LAND;
            cnt_reg         <= '0;
            prev_fish_x_reg <= bus.fish_x;
            riding_reg      <= 1'b0;
            drowned_reg     <= 1'b0;
            respawn_req_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            if (bus.fish_moved) begin
                prev_fish_x_reg <= bus.fish_x;
            end
            riding_reg      <= (state_next == frogger_pkg::RIDE);
            drowned_reg     <= (state_next == frogger_pkg::DROWN) && (state_reg != frogger_pkg::DROWN);
            respawn_req_reg <= (state_next == frogger_pkg::RESPAWN);
        end
    end

    assign bus.riding      = riding_reg;
    assign bus.frog_push   = push_ok && !Reset;
    assign bus.drowned     = drowned_reg;
    assign bus.respawn_req = respawn_req_reg;

endmodule

// File: doc/fish_ride_tracker.md
FISH_RIDE_TRACKER -- requirements
Module: fish_ride_tracker

Interface
REQ-001 Parameter RIVER_Y, default 182: Y coordinate of the fish lane.
REQ-002 Parameter SPRITE_W, default 32: fish and frog sprite width in pixels.
REQ-003 Parameter LEFT_BOUND, default 207: leftmost legal frog X.
REQ-004 Parameter DROWN_HOLD, default 60: cycles spent in DROWN before the respawn request.
REQ-005 frame_clk  in  1: single clock; every register is clocked on its rising edge.
REQ-006 Reset  in  1: synchronous, active-high reset.
REQ-007 fish_x  in  10: fish left-edge X.
REQ-008 fish_y  in  10: fish row Y.
REQ-009 fish_moved  in  1: one-cycle pulse; fish_x changed this cycle (step of -1, or wrap to 431).
REQ-010 frog_x  in  10: frog left-edge X.
REQ-011 frog_y  in  10: frog row Y.
REQ-012 frog_landed  in  1: one-cycle pulse; a frog hop completed this cycle.
REQ-013 respawn_ack  in  1: frog controller has placed the frog at start; level-sampled.
REQ-014 riding  out  1: high while in RIDE.
REQ-015 frog_push  out  1: one-cycle pulse; frog controller must decrement frog X by 1.
REQ-016 drowned  out  1: one-cycle pulse on entry to DROWN.
REQ-017 respawn_req  out  1: high in RESPAWN until acknowledged.

Function
REQ-018 States: LAND, RIDE, DROWN, RESPAWN; state register updates on frame_clk only.
REQ-019 Overlap means frog_x+SPRITE_W/2 >= fish_x and frog_x+SPRITE_W/2 <= fish_x+SPRITE_W-1; sums are computed 11 bits wide, with no truncation.
REQ-020 In LAND, a frog_landed pulse with frog_y==RIVER_Y and overlap moves to RIDE.
REQ-021 In LAND, a frog_landed pulse with frog_y==RIVER_Y and no overlap moves to DROWN.
REQ-022 In LAND, a frog_landed pulse with frog_y!=RIVER_Y keeps the state LAND.
REQ-023 In RIDE, a fish_moved pulse with fish_x == previous fish_x-1 and frog_x > LEFT_BOUND issues frog_push in the same cycle, i.e. 0-cycle latency from fish_moved.
REQ-024 In RIDE, a fish_moved pulse with frog_x <= LEFT_BOUND moves to DROWN and issues no push.
REQ-025 In RIDE, a fish_moved pulse carrying a wrap (new fish_x > previous fish_x) moves to DROWN and issues no push.
REQ-026 The block holds previous fish_x in a register that updates on every fish_moved pulse, in every state.
REQ-027 In RIDE, a frog_landed pulse with frog_y!=RIVER_Y moves to LAND.
REQ-028 In RIDE, a frog_landed pulse with frog_y==RIVER_Y re-evaluates overlap: it stays in RIDE if overlapping, otherwise moves to DROWN.
REQ-029 When fish_moved and frog_landed coincide in RIDE, frog_landed takes priority and frog_push is suppressed that cycle.
REQ-030 drowned pulses exactly one cycle, on the first cycle in DROWN; the DROWN counter then loads 0.
REQ-031 The DROWN counter increments once per cycle; at DROWN_HOLD-1 the state moves to RESPAWN.
REQ-032 In RESPAWN, respawn_req=1; respawn_ack=1 moves to LAND next cycle, otherwise the state holds.
REQ-033 In DROWN and RESPAWN, frog_landed and fish_moved are ignored apart from the previous-fish_x update.
REQ-034 Outputs are registered except frog_push, which is combinational from state and inputs.

Reset
REQ-035 Reset=1 at a rising edge forces, on the next cycle: state=LAND, riding=0, frog_push=0, drowned=0, respawn_req=0, counter=0, previous fish_x=fish_x.
REQ-036 Reset overrides every input in the same cycle, including mid-RIDE and mid-DROWN.

Structure
REQ-037 A shared package frogger_pkg holds the state enum ride_state_t, the lane constant RIVER_Y, SPRITE_W and LEFT_BOUND.
REQ-038 One sub-module, overlap_check, performs the combinational X-overlap compare and is instantiated once.

Verification
REQ-039 fish_x=300, frog_x=290, frog_y=182, frog_landed pulse -> state RIDE and riding=1 next cycle.
REQ-040 In RIDE, fish_moved with fish_x 300->299 -> frog_push=1 for exactly that cycle; 5 moves give 5 pushes.
REQ-041 In RIDE, frog_x=207 and fish_moved -> drowned=1 one cycle later, then respawn_req=1 after 60 cycles; respawn_ack -> LAND.
REQ-042 In RIDE, fish_moved with fish_x 176->431 (wrap) -> DROWN and no frog_push.
REQ-043 frog_landed and fish_moved in the same cycle while in RIDE with frog_y=150 -> LAND and frog_push=0.
REQ-044 Reset asserted for one cycle mid-DROWN (counter=30) -> LAND, all outputs 0, and no respawn_req afterwards.
